mem_bridge: RTL and testbench

Downstream stage of the CPU's 2-way data cache. Services line refills (one 2^WORD_SELECT_BIT-byte line per miss) and write-through word stores by sequencing single-byte transactions on the byte-wide external memory bus. Refill data is returned as one packed line. All bus outputs are registered.

---
 rtl/mem_bridge.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// Byte-wide external memory bridge for the 2-way data cache: line refills and word stores.
// Optional single-entry store buffer enabled with `define MEM_BRIDGE_WBUF_EN.
module mem_bridge #(
  parameter int WORD_SELECT_BIT = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cache_req_i,
  input  logic [31:0]                     cache_addr_i,
  input  logic                            cache_write_i,
  input  logic [31:0]                     cache_write_data_i,
  input  logic [3:0]                      cache_write_mask_i,
  output logic                            cache_rep_o,
  output logic [(8<<WORD_SELECT_BIT)-1:0] cache_rep_data_o,
  output logic                            cache_wack_o,
  output logic                            busy_o,
  output logic [31:0]                     mem_addr_o,
  output logic                            mem_re_o,
  output logic                            mem_we_o,
  output logic [7:0]                      mem_wdata_o,
  input  logic [7:0]                      mem_rdata_i,
  input  logic                            mem_ack_i
);
  localparam int          LINE_W   = 8 << WORD_SELECT_BIT;
  localparam logic [31:0] LOW_MASK = 32'((1 << WORD_SELECT_BIT) - 1);

  typedef enum logic [1:0] {IDLE, RD, RESP, WR} state_t;

  state_t                     state_q, state_d;
  logic [WORD_SELECT_BIT-1:0] cnt_q, cnt_d;
  logic [31:0]                rbase_q, rbase_d;
  logic [LINE_W-1:0]          line_q, line_d, line_nxt;
  logic [31:0]                wbase_q, wbase_d;
  logic [31:0]                wdat_q, wdat_d;
  logic [3:0]                 pend_q, pend_d;
  logic [31:0]                addr_d;
  logic                       re_d, we_d, rep_d, wack_d;
  logic [7:0]                 wdata_d;
  logic [LINE_W-1:0]          repdata_d;
  logic                       store_acc;
  logic                       w_go;
  logic [31:0]                w_base, w_data;
  logic [3:0]                 w_pend;
  logic [1:0]                 w_off;

  // pend[o] = byte offset o still to be written; offset 0 is the MSB lane
  function automatic logic [3:0] rev4(input logic [3:0] m);
    return {m[0], m[1], m[2], m[3]};
  endfunction

  function automatic logic [1:0] first_off(input logic [3:0] p);
    if (p[0]) return 2'd0;
    else if (p[1]) return 2'd1;
    else if (p[2]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] o);
    case (o)
      2'd0:    return d[31:24];
      2'd1:    return d[23:16];
      2'd2:    return d[15:8];
      default: return d[7:0];
    endcase
  endfunction

`ifdef MEM_BRIDGE_WBUF_EN
  logic        wb_vld_q, wb_vld_d;
  logic [31:0] wb_addr_q, wb_addr_d, wb_data_q, wb_data_d;
  logic [3:0]  wb_mask_q, wb_mask_d;

  // The cache holds its store until wack, so the wack cycle itself is never a new store.
  assign store_acc = cache_write_i && !cache_wack_o && !wb_vld_q &&
                     (state_q == IDLE || state_q == WR);
  assign busy_o    = (state_q != IDLE) || (wb_vld_q && cache_write_i);
`else
  assign store_acc = cache_write_i && !cache_wack_o && (state_q == IDLE);
  assign busy_o    = (state_q != IDLE);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rbase_d   = rbase_q;
    line_d    = line_q;
    wbase_d   = wbase_q;
    wdat_d    = wdat_q;
    pend_d    = pend_q;
    addr_d    = mem_addr_o;
    re_d      = mem_re_o;
    we_d      = mem_we_o;
    wdata_d   = mem_wdata_o;
    rep_d     = 1'b0;
    repdata_d = cache_rep_data_o;
    wack_d    = 1'b0;
    w_go      = 1'b0;
    w_base    = wbase_q;
    w_data    = wdat_q;
    w_pend    = pend_q;
    w_off     = 2'd0;
`ifdef MEM_BRIDGE_WBUF_EN
    wb_vld_d  = wb_vld_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_mask_d = wb_mask_q;
`endif
    line_nxt = line_q;
    line_nxt[{cnt_q, 3'b000} +: 8] = mem_rdata_i;

    case (state_q)
      IDLE: begin
        // Buffered store drains first; a store beats a refill to keep program order.
`ifdef MEM_BRIDGE_WBUF_EN
        if (wb_vld_q) begin
          w_go     = 1'b1;
          w_base   = wb_addr_q;
          w_data   = wb_data_q;
          w_pend   = rev4(wb_mask_q);
          wb_vld_d = 1'b0;
        end else
`endif
        if (store_acc) begin
          if (cache_write_mask_i != 4'b0000) begin
            w_go   = 1'b1;
            w_base = cache_addr_i & ~32'h3;
            w_data = cache_write_data_i;
            w_pend = rev4(cache_write_mask_i);
          end
`ifdef MEM_BRIDGE_WBUF_EN
          wack_d = 1'b1;
`else
          wack_d = (cache_write_mask_i == 4'b0000);
`endif
        end else if (cache_req_i) begin
          state_d = RD;
          cnt_d   = '0;
          rbase_d = cache_addr_i & ~LOW_MASK;
          addr_d  = cache_addr_i & ~LOW_MASK;
          re_d    = 1'b1;
        end
      end
      RD: begin
        if (mem_ack_i && mem_re_o) begin
          line_d = line_nxt;
          if (cnt_q == {WORD_SELECT_BIT{1'b1}}) begin
            state_d   = RESP;
            cnt_d     = '0;
            re_d      = 1'b0;
            rep_d     = 1'b1;
            repdata_d = line_nxt;
          end else begin
            cnt_d  = cnt_q + WORD_SELECT_BIT'(1);
            addr_d = rbase_q | 32'(cnt_q + WORD_SELECT_BIT'(1));
          end
        end
      end
      RESP: state_d = IDLE;
      WR: begin
`ifdef MEM_BRIDGE_WBUF_EN
        if (store_acc) begin
          if (cache_write_mask_i != 4'b0000) begin
            wb_vld_d  = 1'b1;
            wb_addr_d = cache_addr_i & ~32'h3;
            wb_data_d = cache_write_data_i;
            wb_mask_d = cache_write_mask_i;
          end
          wack_d = 1'b1;
        end
`endif
        if (mem_ack_i && mem_we_o) begin
          if (pend_q == 4'b0000) begin
            state_d = IDLE;
            we_d    = 1'b0;
`ifndef MEM_BRIDGE_WBUF_EN
            wack_d  = 1'b1;
`endif
          end else begin
            w_go = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Issue the next enabled byte; disabled offsets cost no cycles.
    if (w_go) begin
      w_off   = first_off(w_pend);
      state_d = WR;
      addr_d  = w_base | {30'd0, w_off};
      we_d    = 1'b1;
      re_d    = 1'b0;
      wdata_d = byte_of(w_data, w_off);
      wbase_d = w_base;
      wdat_d  = w_data;
      pend_d  = w_pend & ~(4'b0001 << w_off);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      rbase_q          <= '0;
      line_q           <= '0;
      wbase_q          <= '0;
      wdat_q           <= '0;
      pend_q           <= '0;
      mem_addr_o       <= '0;
      mem_re_o         <= 1'b0;
      mem_we_o         <= 1'b0;
      mem_wdata_o      <= '0;
      cache_rep_o      <= 1'b0;
      cache_rep_data_o <= '0;
      cache_wack_o     <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      rbase_q          <= rbase_d;
      line_q           <= line_d;
      wbase_q          <= wbase_d;
      wdat_q           <= wdat_d;
      pend_q           <= pend_d;
      mem_addr_o       <= addr_d;
      mem_re_o         <= re_d;
      mem_we_o         <= we_d;
      mem_wdata_o      <= wdata_d;
      cache_rep_o      <= rep_d;
      cache_rep_data_o <= repdata_d;
      cache_wack_o     <= wack_d;
    end
  end

`ifdef MEM_BRIDGE_WBUF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_mask_q <= '0;
    end else begin
      wb_vld_q  <= wb_vld_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_mask_q <= wb_mask_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: byte-bus memory model, transaction scoreboard, timing checks.
module tb_mem_bridge;
  localparam int WSB = 3;
  localparam int N   = 1 << WSB;

`ifdef MEM_BRIDGE_WBUF_EN
  localparam int WACK_STORE2 = 1;
  localparam int WACK_STORE4 = 1;
  localparam int REP_AFTER4  = 13;
`else
  localparam int WACK_STORE2 = 3;
  localparam int WACK_STORE4 = 5;
  localparam int REP_AFTER4  = 9;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_req_i, cache_write_i;
  logic [31:0] cache_addr_i, cache_write_data_i;
  logic [3:0]  cache_write_mask_i;
  logic        cache_rep_o, cache_wack_o, busy_o;
  logic [63:0] cache_rep_data_o;
  logic [31:0] mem_addr_o;
  logic        mem_re_o, mem_we_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i = 8'h00;
  logic        mem_ack_i   = 1'b1;

  mem_bridge #(.WORD_SELECT_BIT(WSB)) dut (
    .clk(clk), .rst(rst),
    .cache_req_i(cache_req_i), .cache_addr_i(cache_addr_i),
    .cache_write_i(cache_write_i), .cache_write_data_i(cache_write_data_i),
    .cache_write_mask_i(cache_write_mask_i),
    .cache_rep_o(cache_rep_o), .cache_rep_data_o(cache_rep_data_o),
    .cache_wack_o(cache_wack_o), .busy_o(busy_o),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic we; logic [31:0] addr; logic [7:0] data;} bus_t;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  bus_t        exp_bus [$];
  logic [63:0] exp_line[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          stall_left = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  logic        hold_pend = 1'b0;
  logic [31:0] h_addr;
  logic [1:0]  h_strb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus slave: ack and read data settle just after each rising edge.
  always @(posedge clk) begin
    #1;
    if ((mem_re_o || mem_we_o) && mem_addr_o == stall_addr && stall_left > 0) begin
      mem_ack_i  = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      mem_ack_i = 1'b1;
    end
    mem_rdata_i = mem[mem_addr_o[7:0]];
  end

  // Monitor: scoreboard completed bytes and refill responses mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      hold_pend = 1'b0;
    end else begin
      if (mem_re_o || mem_we_o) chk("re_we_exclusive", 64'(mem_re_o && mem_we_o), 64'd0);
      if (hold_pend) begin
        chk("hold_addr", 64'(mem_addr_o), 64'(h_addr));
        chk("hold_strobe", 64'({mem_re_o, mem_we_o}), 64'(h_strb));
      end
      if ((mem_re_o || mem_we_o) && mem_ack_i) begin
        chk("bus_txn_expected", 64'(exp_bus.size() != 0), 64'd1);
        if (exp_bus.size() != 0) begin
          bus_t e;
          e = exp_bus.pop_front();
          chk("bus_txn", 64'({mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 8'h00}),
                         64'({e.we, e.addr, e.we ? e.data : 8'h00}));
        end
        if (mem_we_o) mem[mem_addr_o[7:0]] = mem_wdata_o;
      end
      hold_pend = (mem_re_o || mem_we_o) && !mem_ack_i;
      h_addr    = mem_addr_o;
      h_strb    = {mem_re_o, mem_we_o};
      if (cache_rep_o) begin
        chk("rep_expected", 64'(exp_line.size() != 0), 64'd1);
        if (exp_line.size() != 0) chk("rep_data", cache_rep_data_o, exp_line.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_refill(input logic [31:0] addr);
    logic [31:0] base;
    logic [63:0] line;
    base = addr & ~32'(N - 1);
    line = '0;
    for (int k = 0; k < N; k++) begin
      exp_bus.push_back('{1'b0, base + 32'(k), ref_mem[8'(base + 32'(k))]});
      line[8*k +: 8] = ref_mem[8'(base + 32'(k))];
    end
    exp_line.push_back(line);
  endtask

  task automatic push_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] a;
    logic [7:0]  b;
    for (int o = 0; o < 4; o++) begin
      if (mask[3-o]) begin
        a = {addr[31:2], 2'b00} + 32'(o);
        b = data[31-8*o -: 8];
        exp_bus.push_back('{1'b1, a, b});
        ref_mem[a[7:0]] = b;
      end
    end
  endtask

  task automatic wait_rep(inout int cyc);
    while (!cache_rep_o && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_wack(inout int cyc);
    while (!cache_wack_o && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int   cyc;
    logic found;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i);
      ref_mem[i] = 8'(i);
    end
    rst = 1'b0;
    cache_req_i = 1'b0; cache_write_i = 1'b0;
    cache_addr_i = '0; cache_write_data_i = '0; cache_write_mask_i = '0;
    #1;
    chk("rst_rep",     64'(cache_rep_o), 64'd0);
    chk("rst_wack",    64'(cache_wack_o), 64'd0);
    chk("rst_busy",    64'(busy_o), 64'd0);
    chk("rst_strobes", 64'({mem_re_o, mem_we_o}), 64'd0);
    chk("rst_addr",    64'(mem_addr_o), 64'd0);
    chk("rst_line",    cache_rep_data_o, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    tick();

    // Zero-wait refill of the line holding 0x13
    push_refill(32'h13);
    cache_req_i = 1'b1; cache_addr_i = 32'h0000_0013;
    tick();
    cyc = 1;
    chk("rd_busy",  64'(busy_o), 64'd1);
    chk("rd_first", 64'({mem_re_o, mem_addr_o}), 64'({1'b1, 32'h10}));
    wait_rep(cyc);
    cache_req_i = 1'b0;
    chk("refill_cycle", 64'(cyc), 64'd9);
    chk("refill_line",  cache_rep_data_o, 64'h1716151413121110);
    tick();
    chk("rep_one_cycle", 64'(cache_rep_o), 64'd0);
    chk("rep_stable",    cache_rep_data_o, 64'h1716151413121110);
    chk("idle_busy",     64'(busy_o), 64'd0);

    // Partial store, mask 1010
    push_store(32'h20, 32'hAABBCCDD, 4'b1010);
    cache_write_i = 1'b1; cache_addr_i = 32'h20;
    cache_write_data_i = 32'hAABBCCDD; cache_write_mask_i = 4'b1010;
    cyc = 0;
    wait_wack(cyc);
    cache_write_i = 1'b0;
    chk("store_wack_cycle", 64'(cyc), 64'(WACK_STORE2));
    repeat (3) tick();
    chk("store_drained", 64'(exp_bus.size()), 64'd0);

    // Empty mask: no bus traffic, wack next cycle
    cache_write_i = 1'b1; cache_addr_i = 32'h24;
    cache_write_data_i = 32'h11223344; cache_write_mask_i = 4'b0000;
    cyc = 0;
    wait_wack(cyc);
    cache_write_i = 1'b0;
    chk("nomask_wack_cycle", 64'(cyc), 64'd1);
    tick();
    chk("nomask_no_bus", 64'({mem_re_o, mem_we_o}), 64'd0);

    // Refill with byte 3 stalled two cycles
    stall_addr = 32'h43; stall_left = 2;
    push_refill(32'h40);
    cache_req_i = 1'b1; cache_addr_i = 32'h40;
    cyc = 0;
    wait_rep(cyc);
    cache_req_i = 1'b0;
    chk("stall_rep_cycle", 64'(cyc), 64'd11);
    chk("stall_used", 64'(stall_left), 64'd0);
    stall_addr = 32'hFFFF_FFFF;
    tick();

    // Store and refill presented together: store first, refill sees new bytes
    push_store(32'h30, 32'h01020304, 4'b1111);
    push_refill(32'h30);
    cache_write_i = 1'b1; cache_req_i = 1'b1; cache_addr_i = 32'h30;
    cache_write_data_i = 32'h01020304; cache_write_mask_i = 4'b1111;
    cyc = 0;
    wait_wack(cyc);
    cache_write_i = 1'b0;
    chk("sr_wack_cycle", 64'(cyc), 64'(WACK_STORE4));
    cyc = 0;
    wait_rep(cyc);
    cache_req_i = 1'b0;
    chk("sr_rep_cycle", 64'(cyc), 64'(REP_AFTER4));
    chk("sr_line", cache_rep_data_o, 64'h3736353404030201);
    tick();

    // Reset while byte 5 of a refill is on the bus
    push_refill(32'h50);
    cache_req_i = 1'b1; cache_addr_i = 32'h50;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (mem_re_o && mem_addr_o == 32'h55) found = 1'b1;
    end
    chk("reach_byte5", 64'(found), 64'd1);
    rst = 1'b0;
    cache_req_i = 1'b0;
    #1;
    chk("mid_rst_strobes", 64'({mem_re_o, mem_we_o, cache_rep_o, cache_wack_o}), 64'd0);
    chk("mid_rst_addr",    64'(mem_addr_o), 64'd0);
    chk("mid_rst_busy",    64'(busy_o), 64'd0);
    chk("mid_rst_line",    cache_rep_data_o, 64'd0);
    exp_bus.delete();
    exp_line.delete();
    tick();
    tick();
    chk("no_rep_after_rst", 64'(cache_rep_o), 64'd0);
    rst = 1'b1;
    tick();
    push_refill(32'h50);
    cache_req_i = 1'b1; cache_addr_i = 32'h57;
    cyc = 0;
    wait_rep(cyc);
    cache_req_i = 1'b0;
    chk("post_rst_cycle", 64'(cyc), 64'd9);
    chk("post_rst_line",  cache_rep_data_o, 64'h5756555453525150);
    tick();

`ifdef MEM_BRIDGE_WBUF_EN
    // Buffered full-word store followed by refill of the same line
    push_store(32'h60, 32'hDEADBEEF, 4'b1111);
    push_refill(32'h60);
    cache_write_i = 1'b1; cache_addr_i = 32'h60;
    cache_write_data_i = 32'hDEADBEEF; cache_write_mask_i = 4'b1111;
    cyc = 0;
    wait_wack(cyc);
    cache_write_i = 1'b0;
    chk("wbuf_wack_cycle", 64'(cyc), 64'd1);
    cache_req_i = 1'b1;
    cyc = 0;
    wait_rep(cyc);
    cache_req_i = 1'b0;
    chk("wbuf_rep_seen", 64'(cache_rep_o), 64'd1);
    chk("wbuf_line", cache_rep_data_o, 64'h67666564EFBEADDE);
    tick();
`endif

    tick();
    chk("end_bus_q",  64'(exp_bus.size()), 64'd0);
    chk("end_line_q", 64'(exp_line.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
